// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a pipelined decode stage.
// Tracks in-flight register writers with one 2-bit counter per register,
// detects RAW and writer-overflow hazards, and sequences a pipeline drain
// through a small RUN/STALL/DRAIN/HALTED state machine.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instD,
    input  logic        validD,
    input  logic        use_src1D,
    input  logic        use_src2D,
    input  logic        wr_destD,
    input  logic        branch_takenD,
    input  logic        write_enW,
    input  logic [3:0]  destAddW,
    input  logic        mem_busy,
    input  logic        drain_req,
    output logic        stallF,
    output logic        stallD,
    output logic        flushD,
    output logic        flushE,
    output logic        issueD,
    output logic        drain_done,
    output logic [15:0] pending,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state_r;
    logic [15:0][1:0]  cnt_r;
    logic [15:0]       stall_cnt_r;

    logic [3:0]        src1_s;
    logic [3:0]        src2_s;
    logic [3:0]        dest_s;
    logic [15:0]       pending_s;
    logic              raw_s;
    logic              full_s;
    logic              hz_s;
    logic              stall_s;
    logic              issue_s;
    logic              all_idle_s;
    logic [15:0]       inc_vec_s;
    logic [15:0]       dec_vec_s;

    assign src1_s = instD[11:8];
    assign src2_s = instD[7:4];
    assign dest_s = instD[3:0];

    // Per-register "has a writer in flight" flags.
    always_comb begin
        pending_s = 16'h0000;
        for (int r = 0; r < 16; r++) begin
            pending_s[r] = (cnt_r[r] != 2'd0);
        end
    end

    // Hazard detection against current counters; no writeback bypass.
    always_comb begin
        raw_s  = validD & ((use_src1D & pending_s[src1_s]) |
                           (use_src2D & pending_s[src2_s]));
        full_s = validD & wr_destD & (cnt_r[dest_s] == 2'd3);
        hz_s   = raw_s | full_s | mem_busy;
    end

    // Stall decision by state: drain states always hold the front end.
    always_comb begin
        stall_s = 1'b1;
        case (state_r)
            RUN, STALL:    stall_s = hz_s;
            DRAIN, HALTED: stall_s = 1'b1;
            default:       stall_s = 1'b1;
        endcase
    end

    assign issue_s    = validD & ~stall_s;
    assign all_idle_s = (pending_s == 16'h0000) & ~mem_busy;

    // One-hot increment/decrement requests for the counter bank.
    always_comb begin
        if (issue_s && wr_destD) begin
            inc_vec_s = 16'h0001 << dest_s;
        end else begin
            inc_vec_s = 16'h0000;
        end
        if (write_enW) begin
            dec_vec_s = 16'h0001 << destAddW;
        end else begin
            dec_vec_s = 16'h0000;
        end
    end

    // Writer counters: same-edge inc+dec cancel, decrement at zero is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= '0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                if (inc_vec_s[r] && !dec_vec_s[r]) begin
                    cnt_r[r] <= cnt_r[r] + 2'd1;
                end else if (!inc_vec_s[r] && dec_vec_s[r] && (cnt_r[r] != 2'd0)) begin
                    cnt_r[r] <= cnt_r[r] - 2'd1;
                end else begin
                    cnt_r[r] <= cnt_r[r];
                end
            end
        end
    end

    // Pipeline control state machine.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN, STALL: begin
                    if (drain_req) begin
                        state_r <= DRAIN;
                    end else if (hz_s) begin
                        state_r <= STALL;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    if (all_idle_s) begin
                        state_r <= HALTED;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                HALTED: begin
                    if (!drain_req) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= HALTED;
                    end
                end
                default: state_r <= RUN;
            endcase
        end
    end

    // Saturating count of cycles spent with decode held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stallF     = stall_s;
    assign stallD     = stall_s;
    assign flushE     = stall_s;
    assign issueD     = issue_s;
    assign flushD     = branch_takenD & issue_s;
    assign drain_done = (state_r == HALTED);
    assign pending    = pending_s;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL use a single clock and a synchronous active-low reset; all ports are listed below.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- instD  in  16  instruction in D; src1=[11:8], src2=[7:4], dest=[3:0]
- validD  in  1  instD holds a real instruction
- use_src1D, use_src2D, wr_destD  in  1 each  operand/dest usage flags for instD
- branch_takenD  in  1  branch in D resolved taken
- write_enW  in  1  register file write this cycle
- destAddW  in  4  register file write address
- mem_busy  in  1  data memory multicycle access in progress
- drain_req  in  1  request to quiesce pipeline
- stallF, stallD  out  1  hold PC and F/D register
- flushD  out  1  squash F/D register contents
- flushE  out  1  insert bubble into D/E register
- issueD  out  1  instD advances to E this cycle
- drain_done  out  1  pipeline empty, issue halted
- pending  out  16  bit r = 1 when register r has any writer in flight
- stall_cnt  out  16  saturating count of stalled cycles

Function
REQ-002 The block SHALL keep a 2-bit in-flight writer counter per register (16 counters); pending[r] = (cnt[r] != 0).
REQ-003 On a clock edge with issueD=1 and wr_destD=1, cnt[dest] SHALL increment; with write_enW=1, cnt[destAddW] SHALL decrement.
REQ-004 Increment and decrement of the same register on the same edge SHALL leave it unchanged; different registers update independently.
REQ-005 A decrement of a counter already at 0 SHALL leave it at 0 (unmatched writeback ignored).
REQ-006 The RAW hazard is raw = validD & ((use_src1D & cnt[src1]!=0) | (use_src2D & cnt[src2]!=0)), evaluated on current-cycle counters; a same-cycle writeback does not clear the hazard (no bypass), so the stall lasts until the edge after the write.
REQ-007 The structural hazard is full = validD & wr_destD & (cnt[dest]==3).
REQ-008 FSM states: RUN, STALL, DRAIN, HALTED; state is registered; outputs are combinational from state, counters and inputs.
REQ-009 In RUN or STALL: hz = raw | full | mem_busy; the next state is STALL if hz, else RUN; if drain_req=1, the next state is DRAIN regardless of hz.
REQ-010 stallF = stallD = flushE = 1 when hz=1 in RUN/STALL, or in DRAIN/HALTED; otherwise 0.
REQ-011 issueD = validD & ~stallD.
REQ-012 flushD = branch_takenD & issueD; a taken branch that is stalled SHALL NOT flush, and SHALL flush on the cycle it issues.
REQ-013 In DRAIN, no issue; the next state is HALTED when all counters are 0 and mem_busy=0.
REQ-014 In HALTED, drain_done=1 and no issue; the next state is RUN when drain_req=0. drain_done=0 in all other states.
REQ-015 stall_cnt SHALL increment on every edge where stallD=1, and saturate at 16'hFFFF.
REQ-016 Counter updates from write_enW SHALL continue in every state, including DRAIN and HALTED.

Reset
REQ-017 While reset=0 at an edge: state=RUN, all cnt=0, stall_cnt=0; reset mid-stall or mid-drain SHALL abandon that operation.
REQ-018 Outputs after reset: pending=0, drain_done=0; stallF, stallD, flushE and flushD are 0 unless inputs create a hazard or branch.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Issue writer to R3 (wr_destD=1, dest=3); next cycle, consumer reads R3 via src1 -> stallD=1 until the edge after write_enW=1/destAddW=3, then issueD=1; stall_cnt equals the number of stalled cycles.
- Three writers to R5 back-to-back, none written back; a fourth writer to R5 -> full stall, cnt[5]=3, pending[5]=1; one writeback to R5 -> fourth issues, cnt[5]=3.
- Issue to R7 and writeback of R7 on the same edge with cnt[7]=1 -> cnt[7] stays 1.
- Taken branch while src2 hazard present -> flushD=0 during stall; flushD=1 on the issue cycle.
- drain_req=1 with cnt[2]=1 and mem_busy=1 -> DRAIN, stalls held; after writeback of R2 and mem_busy=0 -> drain_done=1; drain_req=0 -> RUN next cycle.
- reset=0 asserted during STALL with cnt nonzero -> next cycle pending=0, stall_cnt=0, stallD=0.
